// File: rtl/draw_scheduler_pkg.sv
// Shared types and widths for the draw scheduler slice.
package draw_sched_pkg;

   localparam int unsigned POS_W     = 10;
   localparam int unsigned SLOT_ID_W = 4;
   // One extra bit so the scan index can step past the last slot.
   localparam int unsigned IDX_W     = SLOT_ID_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      LAUNCH,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/draw_watchdog.sv
// Cycle counter guarding the draw_done wait; expired asserts at TIMEOUT-1.
module draw_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer sharing one sprite draw unit among NUM_SLOTS objects.
// Optional erase-before-redraw storage is enabled by defining DRAW_ERASE_EN.
module draw_scheduler
   import draw_sched_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         frame_start,
   input  logic [NUM_SLOTS-1:0]         obj_active,
   input  logic [POS_W*NUM_SLOTS-1:0]   obj_x,
   input  logic [POS_W*NUM_SLOTS-1:0]   obj_y,
   input  logic                         draw_done,
   output logic                         plot,
   output logic [POS_W-1:0]             x_pos,
   output logic [POS_W-1:0]             y_pos,
   output logic [SLOT_ID_W-1:0]         slot_id,
   output logic                         erase,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         timeout_err,
   output logic                         overrun_err
);

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic               in_range;
   logic               scan_hit;
   logic               cur_act;
   logic [POS_W-1:0]   cur_x;
   logic [POS_W-1:0]   cur_y;
   logic               wd_clear;
   logic               wd_en;
   logic               wd_expired;

`ifdef DRAW_ERASE_EN
   logic [POS_W-1:0]     prev_x [NUM_SLOTS];
   logic [POS_W-1:0]     prev_y [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] prev_valid;
   logic [POS_W-1:0]     new_x;
   logic [POS_W-1:0]     new_y;
   logic                 act_q;
   logic                 pend;
   logic                 cur_pv;
   logic [POS_W-1:0]     cur_px;
   logic [POS_W-1:0]     cur_py;
`endif

   assign in_range = (idx < IDX_W'(NUM_SLOTS));
   assign slot_id  = idx[SLOT_ID_W-1:0];

   // Per-slot view of the table at the current scan index.
   always_comb begin
      cur_act = 1'b0;
      cur_x   = '0;
      cur_y   = '0;
`ifdef DRAW_ERASE_EN
      cur_pv  = 1'b0;
      cur_px  = '0;
      cur_py  = '0;
`endif
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_act = obj_active[i];
            cur_x   = obj_x[POS_W*i +: POS_W];
            cur_y   = obj_y[POS_W*i +: POS_W];
`ifdef DRAW_ERASE_EN
            cur_pv  = prev_valid[i];
            cur_px  = prev_x[i];
            cur_py  = prev_y[i];
`endif
         end
      end
   end

`ifdef DRAW_ERASE_EN
   // A pending second pass relaunches the same slot without re-sampling inputs.
   assign scan_hit = pend || (in_range && (cur_act || cur_pv));
`else
   assign scan_hit = in_range && cur_act;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = SCAN;
         SCAN: begin
            if (scan_hit)       state_nxt = LAUNCH;
            else if (!in_range) state_nxt = DONE;
         end
         LAUNCH:  state_nxt = WAIT;
         WAIT:    if (draw_done || wd_expired) state_nxt = SCAN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      plot       = (state == LAUNCH);
      busy       = (state == SCAN) || (state == LAUNCH) || (state == WAIT);
      frame_done = (state == DONE);
      wd_clear   = (state == LAUNCH);
      wd_en      = (state == WAIT);
   end

   draw_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx         <= '0;
         x_pos       <= '0;
         y_pos       <= '0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
`ifdef DRAW_ERASE_EN
         erase       <= 1'b0;
         new_x       <= '0;
         new_y       <= '0;
         act_q       <= 1'b0;
         pend        <= 1'b0;
         prev_valid  <= '0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            prev_x[i] <= '0;
            prev_y[i] <= '0;
         end
`endif
      end else begin
         if (frame_start && (state != IDLE)) overrun_err <= 1'b1;
         if ((state == WAIT) && wd_expired && !draw_done) timeout_err <= 1'b1;

         case (state)
            IDLE: begin
               if (frame_start) idx <= '0;
`ifdef DRAW_ERASE_EN
               pend <= 1'b0;
`endif
            end
            SCAN: begin
               if (scan_hit) begin
`ifdef DRAW_ERASE_EN
                  if (pend) begin
                     x_pos <= new_x;
                     y_pos <= new_y;
                     erase <= 1'b0;
                     pend  <= 1'b0;
                  end else if (cur_pv) begin
                     x_pos <= cur_px;
                     y_pos <= cur_py;
                     erase <= 1'b1;
                     new_x <= cur_x;
                     new_y <= cur_y;
                     act_q <= cur_act;
                  end else begin
                     x_pos <= cur_x;
                     y_pos <= cur_y;
                     erase <= 1'b0;
                  end
`else
                  x_pos <= cur_x;
                  y_pos <= cur_y;
`endif
               end else if (in_range) begin
                  idx <= idx + IDX_W'(1);
               end
            end
            WAIT: begin
               if (draw_done || wd_expired) begin
`ifdef DRAW_ERASE_EN
                  if (erase && act_q) pend <= 1'b1;
                  else                idx  <= idx + IDX_W'(1);
                  for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                     if (idx == IDX_W'(i)) begin
                        if (!erase) begin
                           prev_x[i]     <= x_pos;
                           prev_y[i]     <= y_pos;
                           prev_valid[i] <= 1'b1;
                        end else if (!act_q) begin
                           prev_valid[i] <= 1'b0;
                        end
                     end
                  end
`else
                  idx <= idx + IDX_W'(1);
`endif
               end
            end
            default: ;
         endcase
      end
   end

`ifndef DRAW_ERASE_EN
   assign erase = 1'b0;
`endif

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Frame-level sequencer that shares one sprite drawing unit (plot / x_pos / y_pos / draw_done handshake) among NUM_SLOTS game objects. On each frame_start pulse it walks the slot table in ascending index order, launches one draw per active slot, waits for draw_done, and signals frame_done when the table is exhausted. It sits between the game-state logic (object positions) and the draw unit feeding the VGA write port.

## Interface
- NUM_SLOTS, 8: number of object slots (2..16)
- TIMEOUT, 1024: maximum cycles to wait for draw_done before aborting a slot
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse requesting one drawing pass
- obj_active  in  NUM_SLOTS  per-slot draw request (level)
- obj_x  in  10*NUM_SLOTS  packed x positions, slot i at [10i+9:10i]
- obj_y  in  10*NUM_SLOTS  packed y positions
- draw_done  in  1  single-cycle completion pulse from the draw unit
- plot  out  1  single-cycle launch pulse to the draw unit
- x_pos, y_pos  out  10 each  position for the current draw; stable from launch until next launch
- slot_id  out  4  index of the slot being drawn
- erase  out  1  current draw is an erase pass (draw unit forces color 0)
- busy  out  1  high from frame_start acceptance until frame_done
- frame_done  out  1  single-cycle pulse at end of pass
- timeout_err  out  1  sticky: a slot was aborted by the watchdog
- overrun_err  out  1  sticky: frame_start arrived while busy

## Operation
- States: IDLE, SCAN, LAUNCH, WAIT, DONE.
- IDLE: on frame_start -> SCAN with index 0, busy=1.
- SCAN: examines one slot per cycle. Slot eligible if obj_active[i] (or, with erase, prev_valid[i]). Eligible -> latch obj_x/obj_y of slot i, -> LAUNCH. Not eligible -> index+1. Index past NUM_SLOTS-1 -> DONE.
- LAUNCH: plot=1 for exactly one cycle; -> WAIT; watchdog cleared.
- WAIT: draw_done -> advance (next pass of same slot or index+1, SCAN). Watchdog reaching TIMEOUT-1 -> set timeout_err, advance as if done.
- DONE: frame_done=1 one cycle, busy=0, -> IDLE.
- frame_start outside IDLE: ignored, overrun_err set.
- draw_done outside WAIT: ignored.
- obj_active/obj_x/obj_y sampled only at SCAN of that slot; later changes do not affect the in-flight draw.
- Sticky flags clear only on reset.

## Timing
- Reset: all outputs 0, state IDLE, index 0, watchdog 0, prev_valid all 0.
- frame_start at cycle t -> SCAN slot 0 at t+1; eligible slot at SCAN cycle s -> plot at s+1, x_pos/y_pos valid at s+1.
- draw_done at cycle w -> SCAN next slot at w+1.
- Empty table: frame_done at t+NUM_SLOTS+2.
- Reset mid-pass: immediate return to IDLE, plot deasserted, no frame_done.

## Configuration
- DRAW_ERASE_EN defined: per-slot prev_x/prev_y/prev_valid registers. For an eligible slot with prev_valid, first an erase draw (erase=1) at prev position, then, if obj_active, a normal draw at new position. After a normal draw completes (or times out), prev position <= latched position, prev_valid<=1; inactive slot after its erase -> prev_valid<=0.
- Not defined: no storage, one draw per active slot, erase tied 0.

## Structure
- Package draw_sched_pkg: state enum, POS_W=10, SLOT_ID_W=4.
- Sub-module draw_watchdog: counter with clear/enable inputs and expired output at TIMEOUT-1.

## Test plan
- Slots 1 and 5 active at (10,20),(300,200); frame_start; draw_done 6 cycles after each plot -> two plots, slot_id 1 then 5, correct x/y, frame_done once, timeout_err 0.
- No slots active; frame_start -> frame_done exactly NUM_SLOTS+2 cycles later, no plot.
- Slot 0 active, draw_done never returned -> timeout_err set after TIMEOUT cycles in WAIT, pass completes with frame_done.
- frame_start pulsed while busy -> overrun_err=1, pass count unchanged, single frame_done.
- DRAW_ERASE_EN: slot 2 at (50,60) frame 1, moved to (52,60) frame 2, then deactivated frame 3 -> frame 2 erase (50,60) then draw (52,60); frame 3 single erase (52,60).
- reset asserted in WAIT -> all outputs 0 next cycle; new frame_start starts at slot 0.
